ste_avg_ctrl: RTL
=================

// Module: ste_avg_ctrl
// PURPOSE
//  Run controller sequencing the 1st-order IIR averager (ste_avg_iir). On start it clears the averager and gates incoming sample strobes into avg_en.
//  It discards a programmable settling period, then captures decimated averaged results. Run is continuous or of programmed length.
//  Sits between the sample source / register interface and the averager instance.
// PARAMETERS
//  DATA_W    16  averaged data width (matches averager)
//  CNT_W     16  width of run-length and sample counters
//  DEC_W      8  width of decimation ratio input
//  SETTLE_N  32  samples fed to averager after clear before results are valid; 0 = no settling
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       asynchronous reset, active low
//  start_i       in   1       start run (single-cycle pulse; level tolerated)
//  stop_i        in   1       abort run
//  smp_vld_i     in   1       input sample strobe for averager din
//  num_smp_i     in   CNT_W   RUN-phase sample count; 0 = continuous; sampled at start
//  dec_i         in   DEC_W   decimation: one result per dec_i+1 RUN samples; sampled at start
//  avg_clr_o     out  1       averager clear (to avg_clr_i)
//  avg_en_o      out  1       averager enable (to avg_en_i)
//  avg_dout_i    in   DATA_W  averager dout_o
//  result_o      out  DATA_W  captured averaged result
//  result_vld_o  out  1       one-cycle pulse, result_o updated
//  settled_o     out  1       high while in RUN
//  busy_o        out  1       high in any state except IDLE
//  done_o        out  1       one-cycle pulse on normal run completion
//  smp_cnt_o     out  CNT_W   RUN samples accepted this run, saturating
// BEHAVIOUR
//  Reset: one clock; rst_n async active low. All registered outputs 0; state IDLE; counters 0.
//  FSM states: IDLE, CLEAR, SETTLE, RUN, DONE.
//  - IDLE:   start_i & !stop_i -> CLEAR; latch num_smp_i, dec_i; zero all counters and smp_cnt_o.
//  - CLEAR:  avg_clr_o=1 for exactly this one cycle.
//            Exit: SETTLE if SETTLE_N>0, else RUN; stop_i -> IDLE.
//  - SETTLE: each smp_vld_i increments settle counter. Exit: on the SETTLE_N-th valid -> RUN.
//  - RUN:    each smp_vld_i is an accepted sample.
//            smp_cnt_o += 1, saturating at 2^CNT_W-1.
//            Decimation counter counts 0..dec; on wrap-to-0 sample, result_o <= avg_dout_i.
//            result_vld_o is high the following cycle.
//            num_smp!=0: the num_smp-th accepted sample always captures a result, regardless of decimation phase; -> DONE.
//  - DONE:   done_o=1 for one cycle; -> IDLE.
//  avg_en_o = smp_vld_i & (state==SETTLE | state==RUN). Combinational from the registered state, zero latency.
//    Samples in IDLE/CLEAR/DONE are dropped (no avg_en).
//  Capture takes avg_dout_i in the same cycle as avg_en_o, i.e. the value being committed to the averager.
//  Result latency: 1 clk from strobe to result_vld_o.
//  result_o holds its last value until the next capture, including across runs; it is reset only by rst_n.
//  settled_o = (state==RUN); busy_o = (state!=IDLE). Both are registered-state decodes.
//  stop_i in CLEAR/SETTLE/RUN -> IDLE next cycle. Effects of stop:
//    - a valid sample in the same cycle is dropped: no avg_en, no capture.
//    - no done_o.
//    - averager not cleared until the next start.
//  stop_i in DONE: ignored; done_o still pulses.
//  start_i while busy: ignored. start_i & stop_i together in IDLE: stay IDLE.
//  dec_i=0: every RUN sample produces a result.
//  num_smp_i=0: RUN is continuous until stop_i; smp_cnt_o saturates, no wrap.
//  Async reset mid-run: immediate return to IDLE and all registered outputs 0. avg_en_o drops with state.
// TESTING
//  1 SETTLE_N=4, dec=0, num=3, smp_vld every cycle after start:
//    avg_clr_o 1 cycle; 4 strobes absorbed; 3 result_vld pulses; done_o 1 cycle after 3rd; smp_cnt_o=3.
//  2 dec=3, num=10, vld every 2nd cycle:
//    results on RUN samples 1,5,9,10 (forced final); done_o once; avg_en_o mirrors vld only in SETTLE/RUN.
//  3 num=0, CNT_W=4, 20 RUN samples: smp_cnt_o saturates at 15; no done_o.
//    stop_i -> busy_o low next cycle; vld in stop cycle gives no avg_en_o.
//  4 start_i pulses during RUN: no re-clear, counters unchanged.
//    start&stop together in IDLE: busy_o stays 0.
//  5 rst_n low mid-SETTLE: all outputs 0 immediately; avg_en_o=0 with vld high.
//    New start after release: full CLEAR and SETTLE again.
//  6 SETTLE_N=0 build: start -> CLEAR -> RUN.
//    First vld after CLEAR captures avg_dout_i; result_vld_o next cycle with that value.

Source files
------------

// File: rtl/ste_avg_ctrl.sv
// Run controller for the 1st-order IIR averager: clears it on start, gates sample
// strobes into it, discards a settling period, then captures decimated results.
module ste_avg_ctrl #(
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16,
    parameter int DEC_W    = 8,
    parameter int SETTLE_N = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              smp_vld_i,
    input  logic [CNT_W-1:0]  num_smp_i,
    input  logic [DEC_W-1:0]  dec_i,
    output logic              avg_clr_o,
    output logic              avg_en_o,
    input  logic [DATA_W-1:0] avg_dout_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_vld_o,
    output logic              settled_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  smp_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_e;

    // Settle counter holds 0..SETTLE_N-1; the SETTLE_N-th strobe leaves SETTLE.
    localparam int SET_W = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_N > 0) ? (SETTLE_N - 1) : 0);

    state_e             state_q, state_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [DEC_W-1:0]   dec_q, dec_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               result_vld_q, result_vld_d;

    logic accept_set;
    logic accept_run;
    logic last_smp;
    logic capture;

    always_comb begin
        accept_set = smp_vld_i & ~stop_i & (state_q == S_SETTLE);
        accept_run = smp_vld_i & ~stop_i & (state_q == S_RUN);
        // With a programmed length, smp_cnt never exceeds num_q, so saturation cannot mask the last sample.
        last_smp   = (num_q != '0) && (smp_cnt_q == (num_q - CNT_W'(1)));
        capture    = accept_run & ((dec_cnt_q == '0) | last_smp);
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        dec_d        = dec_q;
        num_d        = num_q;
        smp_cnt_d    = smp_cnt_q;
        result_d     = capture ? avg_dout_i : result_q;
        result_vld_d = capture;

        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d      = S_CLEAR;
                    num_d        = num_smp_i;
                    dec_d        = dec_i;
                    settle_cnt_d = '0;
                    dec_cnt_d    = '0;
                    smp_cnt_d    = '0;
                end
            end
            S_CLEAR: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (SETTLE_N > 0) begin
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_SETTLE: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (accept_set) begin
                    if (settle_cnt_q == SET_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SET_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (accept_run) begin
                    dec_cnt_d = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + DEC_W'(1);
                    if (smp_cnt_q != '1) begin
                        smp_cnt_d = smp_cnt_q + CNT_W'(1);
                    end
                    if (last_smp) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            dec_cnt_q    <= '0;
            dec_q        <= '0;
            num_q        <= '0;
            smp_cnt_q    <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            dec_q        <= dec_d;
            num_q        <= num_d;
            smp_cnt_q    <= smp_cnt_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
        end
    end

    always_comb begin
        avg_en_o     = accept_set | accept_run;
        avg_clr_o    = (state_q == S_CLEAR);
        settled_o    = (state_q == S_RUN);
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_DONE);
        smp_cnt_o    = smp_cnt_q;
        result_o     = result_q;
        result_vld_o = result_vld_q;
    end

endmodule
